// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, requester ids and
// default bus widths.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_EX = 1'b1
    } req_id_e;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester, memory and power-control signals around the arbiter.
// The arbiter attaches through the slave modport; its environment uses master.
interface data_mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              ex_req;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rdata;
    logic              ex_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              powerdown;
    logic              idle;

    modport slave (
        input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata, powerdown,
        output if_valid, if_rdata, ex_valid, ex_rdata, ex_done,
               mem_en, mem_we, mem_addr, mem_wdata, idle
    );

    modport master (
        output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata, powerdown,
        input  if_valid, if_rdata, ex_valid, ex_rdata, ex_done,
               mem_en, mem_we, mem_addr, mem_wdata, idle
    );
endinterface

// File: rtl/data_mem_arbiter_starve_ctr.sv
// Fixed execute-first priority pick with a saturating streak counter that
// forces a fetch grant after STARVE_MAX execute grants made while fetch waited.
module arb_starve_ctr import mem_arb_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    if_req_i,
    input  logic    ex_req_i,
    input  logic    grant_i,
    output req_id_e winner_o
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] streak_q, streak_d;
    logic             starved;

    always_comb begin
        starved  = (streak_q == CNT_W'(STARVE_MAX)) && if_req_i;
        winner_o = (ex_req_i && !starved) ? REQ_EX : REQ_IF;
        streak_d = streak_q;
        if (grant_i) begin
            if (winner_o == REQ_EX && if_req_i) begin
                if (streak_q != CNT_W'(STARVE_MAX)) begin
                    streak_d = streak_q + CNT_W'(1);
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises fetch reads and execute loads/stores onto one single-ported data
// memory: one access in flight, IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module data_mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    req_id_e           win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
    logic              grant;
    req_id_e           winner;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (bus.if_req),
        .ex_req_i (bus.ex_req),
        .grant_i  (grant),
        .winner_o (winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ex_rdata_d = ex_rdata_q;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.powerdown && (bus.if_req || bus.ex_req)) begin
                    grant   = 1'b1;
                    win_d   = winner;
                    state_d = ISSUE;
                    if (winner == REQ_EX) begin
                        addr_d  = bus.ex_addr;
                        we_d    = bus.ex_we;
                        wdata_d = bus.ex_wdata;
                    end else begin
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                // cnt_q reaches zero in cycle ISSUE+MEM_LAT, when mem_rdata is valid
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (win_q == REQ_EX) begin
                        ex_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= REQ_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ex_rdata_q <= ex_rdata_d;
        end
    end

    // Memory-side outputs are forced to zero outside the single ISSUE cycle
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = (state_q == ISSUE) ? addr_q : '0;
    assign bus.mem_wdata = ((state_q == ISSUE) && we_q) ? wdata_q : '0;
    assign bus.if_valid  = (state_q == RESP) && (win_q == REQ_IF);
    assign bus.ex_valid  = (state_q == RESP) && (win_q == REQ_EX) && !we_q;
    assign bus.ex_done   = (state_q == RESP) && (win_q == REQ_EX) && we_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ex_rdata  = ex_rdata_q;
    assign bus.idle      = (state_q == IDLE) && bus.powerdown;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: requester drivers push expected
// responses, a monitor pops and compares them as pulses appear.
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        bit          is_store;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t ex_q[$];
    exp_t if_q[$];
    int   order_log[$];
    int   exp_order[$];

    logic [15:0] mem     [256];
    bit          written [256];
    logic [15:0] ref_mem [256];
    logic [15:0] rd_pipe [MEM_LAT];

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    data_mem_arbiter #(
        .ADDR_W(8), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'hB4) return 16'h002D;
        return {a, ~a} ^ 16'h1357;
    endfunction

    function automatic logic [15:0] mem_val(input logic [7:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    // Memory model: read data appears MEM_LAT cycles after the strobe, junk otherwise
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];
    always @(posedge clk) begin
        for (int k = MEM_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_val(bus.mem_addr) : 16'($urandom);
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   npulse;
        bit   prev_en;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_en = 1'b0;
                continue;
            end
            npulse = int'(bus.if_valid) + int'(bus.ex_valid) + int'(bus.ex_done);
            if (npulse != 0) chk("one_pulse", npulse, 1);
            if (bus.mem_en) chk("mem_en_single", prev_en, 0);
            prev_en = bus.mem_en;
            if (bus.if_valid) begin
                order_log.push_back(int'(REQ_IF));
                if (if_q.size() == 0) chk("if_spurious", 1, 0);
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", bus.if_rdata, e.data);
                    if (e.cyc >= 0) chk("if_cycle", cyc, e.cyc);
                end
            end
            if (bus.ex_valid || bus.ex_done) begin
                order_log.push_back(int'(REQ_EX));
                if (ex_q.size() == 0) chk("ex_spurious", 1, 0);
                else begin
                    e = ex_q.pop_front();
                    chk("ex_kind", bus.ex_done, e.is_store);
                    if (!e.is_store) chk("ex_rdata", bus.ex_rdata, e.data);
                    if (e.cyc >= 0) chk("ex_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the response cycle.
    task automatic ex_access(input logic we, input logic [7:0] a, input logic [15:0] wd,
                             input bit keep, input int lat, input bit chk_iss);
        exp_t e;
        int   t;
        bit   got;
        bus.ex_req = 1'b1; bus.ex_we = we; bus.ex_addr = a; bus.ex_wdata = wd;
        t = cyc;
        e.is_store = we;
        e.cyc = (lat >= 0) ? t + lat : -1;
        if (we) begin
            ref_mem[a] = wd;
            e.data = wd;
        end else begin
            e.data = ref_mem[a];
        end
        ex_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (chk_iss && i == 0) begin
                chk("ex_issue_en", bus.mem_en, 1);
                chk("ex_issue_we", bus.mem_we, we);
                chk("ex_issue_addr", bus.mem_addr, a);
                if (we) chk("ex_issue_wdata", bus.mem_wdata, wd);
            end
            if (bus.ex_valid || bus.ex_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ex_timeout", 0, 1);
        @(negedge clk);
        if (!keep) bus.ex_req = 1'b0;
    endtask

    task automatic if_access(input logic [7:0] a, input bit keep, input int lat, input bit chk_iss);
        exp_t e;
        int   t;
        bit   got;
        bus.if_req = 1'b1; bus.if_addr = a;
        t = cyc;
        e.is_store = 1'b0;
        e.cyc  = (lat >= 0) ? t + lat : -1;
        e.data = ref_mem[a];
        if_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (chk_iss && i == 0) begin
                chk("if_issue_en", bus.mem_en, 1);
                chk("if_issue_addr", bus.mem_addr, a);
            end
            if (bus.if_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("if_timeout", 0, 1);
        @(negedge clk);
        if (!keep) bus.if_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_if_valid"}, bus.if_valid, 0);
        chk({tag, "_ex_valid"}, bus.ex_valid, 0);
        chk({tag, "_ex_done"}, bus.ex_done, 0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 0);
        chk({tag, "_ex_rdata"}, bus.ex_rdata, 0);
        chk({tag, "_idle"}, bus.idle, 0);
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_order_len"}, order_log.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < order_log.size(); i++)
            chk({tag, "_order"}, order_log[i], exp_order[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ex_req = 1'b0; bus.ex_we = 1'b0; bus.ex_addr = '0; bus.ex_wdata = '0;
        bus.powerdown = 1'b0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single load and single store with exact latencies
        ex_access(1'b0, 8'hB4, 16'h0000, 1'b0, 2 + MEM_LAT, 1'b1);
        @(negedge clk);
        ex_access(1'b1, 8'h20, 16'h0036, 1'b0, 2, 1'b1);
        @(negedge clk);
        ex_access(1'b0, 8'h20, 16'h0000, 1'b0, 2 + MEM_LAT, 1'b1);
        chk("store_readback", bus.ex_rdata, 16'h0036);
        @(negedge clk);

        // Simultaneous requests: execute first, fetch right behind it
        order_log.delete();
        exp_order = '{int'(REQ_EX), int'(REQ_IF)};
        fork
            ex_access(1'b0, 8'h44, 16'h0000, 1'b0, 2 + MEM_LAT, 1'b1);
            if_access(8'hA0, 1'b0, 5 + 2 * MEM_LAT, 1'b0);
        join
        chk_order("tie");
        @(negedge clk);

        // Reset while a load waits for memory data
        bus.ex_req = 1'b1; bus.ex_we = 1'b0; bus.ex_addr = 8'h10;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        bus.ex_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        if_access(8'h90, 1'b0, 2 + MEM_LAT, 1'b1);
        @(negedge clk);

        // Starvation guard with both requesters continuously pending
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        order_log.delete();
        exp_order.delete();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < STARVE_MAX; k++) exp_order.push_back(int'(REQ_EX));
            exp_order.push_back(int'(REQ_IF));
        end
        fork
            for (int k = 0; k < 2 * STARVE_MAX; k++)
                ex_access(1'b0, 8'($urandom), 16'h0000, (k < 2 * STARVE_MAX - 1), -1, 1'b0);
            for (int k = 0; k < 2; k++)
                if_access(8'h80 + 8'(k), (k == 0), -1, 1'b0);
        join
        chk_order("starve");
        @(negedge clk);

        // Powerdown raised during the ISSUE cycle of an execute load
        fork
            ex_access(1'b0, 8'h33, 16'h0000, 1'b0, 2 + MEM_LAT, 1'b1);
            if_access(8'hC8, 1'b0, -1, 1'b0);
            begin
                @(posedge clk);
                #2 bus.powerdown = 1'b1;
                repeat (MEM_LAT + 2) @(posedge clk);
                #1;
                chk("pd_idle", bus.idle, 1);
                for (int k = 0; k < 4; k++) begin
                    chk("pd_no_mem_en", bus.mem_en, 0);
                    chk("pd_idle_held", bus.idle, 1);
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                bus.powerdown = 1'b0;
                @(posedge clk);
                #1;
                chk("pd_resume_en", bus.mem_en, 1);
                chk("pd_resume_addr", bus.mem_addr, 8'hC8);
                chk("pd_resume_we", bus.mem_we, 0);
            end
        join
        @(negedge clk);

        // Randomised traffic from both requesters with sporadic powerdown
        fork
            for (int k = 0; k < 40; k++) begin
                logic we;
                bit   keep;
                we   = 1'($urandom);
                keep = ($urandom_range(0, 2) == 0);
                ex_access(we, we ? 8'($urandom_range(0, 127)) : 8'($urandom), 16'($urandom),
                          keep, -1, 1'b0);
                if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int k = 0; k < 40; k++) begin
                if_access(8'($urandom_range(128, 255)), 1'b0, -1, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(5, 20)) @(negedge clk);
                bus.powerdown = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                bus.powerdown = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("ex_queue_drained", ex_q.size(), 0);
        chk("if_queue_drained", if_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
